data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder.sv | 128 ++++++++++++
 tb/tb_data_mem_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the pipeline memory stage (master) and the data-memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory: accepts one load/store, holds it LATENCY cycles, then pulses a response
// while stalling the pipeline for the duration of the access.
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  data_mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        count;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  logic              err_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;

  // Contents survive reset; only time-zero initialisation clears them.
  logic [31:0]       mem [DEPTH] = '{default: '0};

  logic              accept;
  logic              enter_resp;
  logic              cur_write;
  logic              cur_err;
  logic [ADDR_W-1:0] cur_idx;
  logic [31:0]       cur_wdata;

  // With LATENCY=1 the commit happens on the accepting edge, so the live request is used in IDLE.
  always_comb begin
    accept     = (state == IDLE) && bus.req_valid;
    cur_idx    = idx_q;
    cur_wdata  = wdata_q;
    cur_write  = write_q;
    cur_err    = err_q;
    if (state == IDLE) begin
      cur_idx   = bus.req_addr[ADDR_W+1:2];
      cur_wdata = bus.req_wdata;
      cur_write = bus.req_write;
      cur_err   = (bus.req_addr[1:0] != 2'b00);
    end
    enter_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && (count == 4'd1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q       <= cur_idx;
            wdata_q     <= cur_wdata;
            write_q     <= cur_write;
            err_q       <= cur_err;
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              count <= COUNT_INIT;
            end
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
      // Stores leave the read-data register untouched; misaligned accesses force it to zero.
      if (enter_resp) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= cur_err;
        if (cur_err) begin
          resp_rdata_q <= '0;
        end else if (!cur_write) begin
          resp_rdata_q <= mem[cur_idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && enter_resp && cur_write && !cur_err) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.stall      = ((state == IDLE) && bus.req_valid) || (state == WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: four responders with LATENCY 2, 1, 4, 3 exercised one at a time with directed loads/stores.
module tb_data_mem_responder;
  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  logic [3:0]       reset_v;
  logic [3:0]       req_valid_v;
  logic [3:0]       req_write_v;
  logic [3:0][31:0] req_addr_v;
  logic [3:0][31:0] req_wdata_v;
  logic [3:0]       req_ready_v;
  logic [3:0]       resp_valid_v;
  logic [3:0]       resp_err_v;
  logic [3:0]       stall_v;
  logic [3:0][31:0] resp_rdata_v;
  logic [3:0][31:0] acc_addr_v;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_mem_responder_if ifc ();
    assign ifc.req_valid    = req_valid_v[g];
    assign ifc.req_write    = req_write_v[g];
    assign ifc.req_addr     = req_addr_v[g];
    assign ifc.req_wdata    = req_wdata_v[g];
    assign req_ready_v[g]   = ifc.req_ready;
    assign resp_valid_v[g]  = ifc.resp_valid;
    assign resp_err_v[g]    = ifc.resp_err;
    assign stall_v[g]       = ifc.stall;
    assign resp_rdata_v[g]  = ifc.resp_rdata;
    assign acc_addr_v[g]    = ifc.req_addr;

    data_mem_responder #(
      .ADDR_W (8),
      .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 3)
    ) dut (
      .clk  (clk),
      .reset(reset_v[g]),
      .bus  (ifc)
    );
  end

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      default: return 3;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Drive one request, push its expected response, and check handshake/stall until the response cycle.
  task automatic applyStimulus(input int i, input logic write, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, input logic keep);
    int budget;
    int lat;
    lat = lat_of(i);
    @(posedge clk);
    #1;
    req_valid_v[i] = 1'b1;
    req_write_v[i] = write;
    req_addr_v[i]  = addr;
    req_wdata_v[i] = wdata;
    budget = 0;
    @(negedge clk);
    while (!req_ready_v[i] && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready_v[i]) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: inst %0d req_ready stayed %b, required 1", i, req_ready_v[i]);
      req_valid_v[i] = 1'b0;
      return;
    end
    checkOutput("stall_request", 32'(stall_v[i]), 32'd1);
    $display("[TB] inst %0d accepting %s at addr %h", i, write ? "store" : "load", acc_addr_v[i]);
    sb_q.push_back('{inst: i, rdata: exp_rdata, err: exp_err, cyc: cyc + lat});
    @(posedge clk);
    #1;
    if (!keep) req_valid_v[i] = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      checkOutput("ready_busy", 32'(req_ready_v[i]), 32'd0);
      checkOutput("stall_busy", 32'(stall_v[i]), (k < lat) ? 32'd1 : 32'd0);
    end
  endtask

  // Monitor: every response pulse is matched against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid_v[i] === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_resp: inst %0d rdata %h at cycle %0d, required no response",
                   i, resp_rdata_v[i], cyc);
        end else begin
          e = sb_q.pop_front();
          checkOutput("resp_inst", 32'(i), 32'(e.inst));
          checkOutput("resp_cycle", 32'(cyc), 32'(e.cyc));
          checkOutput("resp_rdata", resp_rdata_v[i], e.rdata);
          checkOutput("resp_err", 32'(resp_err_v[i]), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_v     = '1;
    req_valid_v = '0;
    req_write_v = '0;
    req_addr_v  = '0;
    req_wdata_v = '0;
    req_valid_v[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checkOutput("reset_ready", 32'(req_ready_v[i]), 32'd1);
      checkOutput("reset_valid", 32'(resp_valid_v[i]), 32'd0);
      checkOutput("reset_rdata", resp_rdata_v[i], 32'd0);
      checkOutput("reset_err", 32'(resp_err_v[i]), 32'd0);
      checkOutput("reset_stall", 32'(stall_v[i]), (i == 0) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    req_valid_v = '0;
    reset_v     = '0;

    // Store then load back, LATENCY=2.
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ready_after_resp", 32'(req_ready_v[0]), 32'd1);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    // Misaligned store must not write word 0 and must zero the read data.
    applyStimulus(0, 1'b1, 32'h3, 32'h12345678, 32'h0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Upper address bits alias onto word 0; a store keeps the previous read data.
    applyStimulus(0, 1'b1, 32'h400, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h44, 32'h00000077, 32'hA5A5A5A5, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h44, 32'h0, 32'h00000077, 1'b0, 1'b0);

    // LATENCY=1, req_valid held high across two loads.
    applyStimulus(1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ready_after_b2b", 32'(req_ready_v[1]), 32'd1);

    // LATENCY=4: reset during the last WAIT cycle abandons the store.
    @(posedge clk);
    #1;
    req_valid_v[2] = 1'b1;
    req_write_v[2] = 1'b1;
    req_addr_v[2]  = 32'h20;
    req_wdata_v[2] = 32'h1;
    @(negedge clk);
    checkOutput("abort_accept_ready", 32'(req_ready_v[2]), 32'd1);
    @(posedge clk);
    #1;
    req_valid_v[2] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput("abort_no_resp", 32'(resp_valid_v[2]), 32'd0);
      if (k == 4) checkOutput("abort_ready", 32'(req_ready_v[2]), 32'd1);
      @(posedge clk);
      #1;
      reset_v[2] = (k == 2);
    end
    applyStimulus(2, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);

    // LATENCY=3: dropping req_valid after acceptance does not cancel the store.
    applyStimulus(3, 1'b1, 32'h8, 32'h55, 32'h0, 1'b0, 1'b0);
    applyStimulus(3, 1'b0, 32'h8, 32'h0, 32'h55, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
